// File: rtl/softusb_pkg.sv
// Shared constants and state encoding for the softusb transmit path.
package softusb_pkg;
  localparam logic [7:0] SYNC_BYTE     = 8'h80;
  localparam int         FS_BIT_CYCLES = 4;
  localparam int         LS_BIT_CYCLES = 32;
  localparam int         STUFF_LIMIT   = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP1,
    ST_EOP2,
    ST_EOPJ
  } tx_state_t;
endpackage

// File: rtl/softusb_tx_nrzi.sv
// NRZI line encoder: tracks line level (J/K/SE0) and the run of emitted ones.
module softusb_tx_nrzi
  import softusb_pkg::*;
(
  input  logic usb_clk,
  input  logic txreset,
  input  logic i_adv,
  input  logic i_bit,
  input  logic i_se0,
  input  logic i_j,
  input  logic i_ls,
  output logic o_stuff_req,
  output logic o_txp,
  output logic o_txm
);
  logic       r_k;
  logic       r_se0;
  logic [2:0] r_ones;

  // A stuff bit is just an emitted 0, so it clears the run like any data 0.
  always_ff @(posedge usb_clk or posedge txreset) begin
    if (txreset) begin
      r_k    <= 1'b0;
      r_se0  <= 1'b0;
      r_ones <= 3'd0;
    end else if (i_adv) begin
      if (i_se0) begin
        r_se0  <= 1'b1;
        r_ones <= 3'd0;
      end else if (i_j) begin
        r_se0  <= 1'b0;
        r_k    <= 1'b0;
        r_ones <= 3'd0;
      end else begin
        r_se0 <= 1'b0;
        if (i_bit) begin
          r_ones <= r_ones + 3'd1;
        end else begin
          r_k    <= ~r_k;
          r_ones <= 3'd0;
        end
      end
    end
  end

  assign o_stuff_req = (r_ones == 3'(STUFF_LIMIT));
  assign o_txp       = ~r_se0 & (r_k ? i_ls : ~i_ls);
  assign o_txm       = ~r_se0 & (r_k ? ~i_ls : i_ls);
endmodule

// File: rtl/softusb_tx.sv
// USB 1.1 FS/LS transmitter: SYNC, bit-stuffed NRZI payload, EOP; bare keep-alive EOPs.
module softusb_tx
  import softusb_pkg::*;
(
  input  logic       usb_clk,
  input  logic       txreset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       generate_eop,
  output logic       tx_busy,
  input  logic       low_speed,
  output logic       txp,
  output logic       txm,
  output logic       txoe
);
  localparam logic [4:0] FS_LAST = 5'(FS_BIT_CYCLES - 1);
  localparam logic [4:0] LS_LAST = 5'(LS_BIT_CYCLES - 1);

  tx_state_t  r_state, w_nxt;
  logic [4:0] r_div;
  logic [2:0] r_idx, w_idx_nxt, w_idx_inc;
  logic       r_stuff, w_stuff_nxt;
  logic [7:0] r_byte, w_cur_byte;
  logic       r_ls_l, w_ls;
  logic       w_bit_ce, w_stuff_req, w_load;
  logic       w_adv, w_bit, w_se0, w_j;

  assign w_ls       = (r_state == ST_IDLE) ? low_speed : r_ls_l;
  assign w_bit_ce   = (r_div == (r_ls_l ? LS_LAST : FS_LAST));
  assign w_cur_byte = (r_state == ST_SYNC) ? SYNC_BYTE : r_byte;
  assign w_idx_inc  = r_idx + 3'd1;
  assign tx_busy    = (r_state != ST_IDLE);
  assign txoe       = (r_state != ST_IDLE);

  always_ff @(posedge usb_clk or posedge txreset) begin
    if (txreset) begin
      r_state <= ST_IDLE;
      r_div   <= 5'd0;
      r_idx   <= 3'd0;
      r_stuff <= 1'b0;
      r_byte  <= 8'd0;
      r_ls_l  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_idx   <= w_idx_nxt;
      r_stuff <= w_stuff_nxt;
      if (w_load) r_byte <= tx_data;
      // Keep following low_speed while idle so the start edge captures it.
      if (r_state == ST_IDLE) begin
        r_div  <= 5'd0;
        r_ls_l <= low_speed;
      end else begin
        r_div <= w_bit_ce ? 5'd0 : r_div + 5'd1;
      end
    end
  end

  // Decisions are taken at the end of the current symbol and pick the next one.
  always_comb begin
    w_nxt       = r_state;
    w_idx_nxt   = r_idx;
    w_stuff_nxt = r_stuff;
    w_adv       = 1'b0;
    w_bit       = 1'b1;
    w_se0       = 1'b0;
    w_j         = 1'b0;
    w_load      = 1'b0;
    tx_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (tx_valid) begin
          w_nxt       = ST_SYNC;
          w_adv       = 1'b1;
          w_bit       = SYNC_BYTE[0];
          w_idx_nxt   = 3'd0;
          w_stuff_nxt = 1'b0;
        end else if (generate_eop) begin
          w_nxt = ST_EOP1;
          w_adv = 1'b1;
          w_se0 = 1'b1;
        end
      end
      ST_SYNC, ST_DATA: begin
        if (w_bit_ce) begin
          w_adv = 1'b1;
          if (w_stuff_req) begin
            w_bit       = 1'b0;
            w_stuff_nxt = 1'b1;
          end else if (r_idx != 3'd7) begin
            w_bit       = w_cur_byte[w_idx_inc];
            w_idx_nxt   = w_idx_inc;
            w_stuff_nxt = 1'b0;
          end else begin
            w_stuff_nxt = 1'b0;
            if (tx_valid) begin
              tx_ready  = 1'b1;
              w_load    = 1'b1;
              w_nxt     = ST_DATA;
              w_bit     = tx_data[0];
              w_idx_nxt = 3'd0;
            end else begin
              w_nxt = ST_EOP1;
              w_se0 = 1'b1;
            end
          end
        end
      end
      ST_EOP1: begin
        if (w_bit_ce) begin
          w_nxt = ST_EOP2;
          w_adv = 1'b1;
          w_se0 = 1'b1;
        end
      end
      ST_EOP2: begin
        if (w_bit_ce) begin
          w_nxt = ST_EOPJ;
          w_adv = 1'b1;
          w_j   = 1'b1;
        end
      end
      ST_EOPJ: begin
        if (w_bit_ce) w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  softusb_tx_nrzi u_nrzi (
    .usb_clk     (usb_clk),
    .txreset     (txreset),
    .i_adv       (w_adv),
    .i_bit       (w_bit),
    .i_se0       (w_se0),
    .i_j         (w_j),
    .i_ls        (w_ls),
    .o_stuff_req (w_stuff_req),
    .o_txp       (txp),
    .o_txm       (txm)
  );
endmodule

// File: tb/tb_softusb_tx.sv
// Directed bench for softusb_tx: line symbols per cycle, handshake timing, reset, keep-alive.
module tb_softusb_tx;
  logic       usb_clk = 1'b0;
  logic       txreset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       generate_eop;
  logic       tx_busy;
  logic       low_speed;
  logic       txp, txm, txoe;

  int checks = 0;
  int failures = 0;
  int nrdy, rdy1, rdy2;
  logic [7:0] dq[$];

  always #10 usb_clk = ~usb_clk;

  softusb_tx dut (
    .usb_clk      (usb_clk),
    .txreset      (txreset),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .generate_eop (generate_eop),
    .tx_busy      (tx_busy),
    .low_speed    (low_speed),
    .txp          (txp),
    .txm          (txm),
    .txoe         (txoe)
  );

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // {txoe, tx_busy, txp, txm} expected for an idle line with polarity ls
  function automatic logic [3:0] idle_exp(input logic ls);
    return {2'b00, ~ls, ls};
  endfunction

  task automatic start_pkt();
    @(negedge usb_clk);
    tx_valid = 1'b1;
    tx_data  = dq[0];
    @(posedge usb_clk);
    #1;
  endtask

  // Checks each cycle of the symbol string; feeds dq on every tx_ready.
  task automatic run(input string tag, input string sym, input int bc, input logic ls,
                     input int abort_at);
    int total;
    byte ch;
    logic [1:0] e;
    logic hit;
    total = sym.len() * bc;
    nrdy = 0; rdy1 = 0; rdy2 = 0;
    for (int k = 1; k <= total; k++) begin
      @(negedge usb_clk);
      ch = sym[(k - 1) / bc];
      if (ch == "K") e = {ls, ~ls};
      else if (ch == "J") e = {~ls, ls};
      else e = 2'b00;
      chk4({tag, "_line"}, {txoe, tx_busy, txp, txm}, {2'b11, e});
      hit = tx_ready;
      if (hit) begin
        nrdy++;
        if (nrdy == 1) rdy1 = k;
        if (nrdy == 2) rdy2 = k;
      end
      if (k == abort_at) return;
      @(posedge usb_clk);
      #1;
      if (hit) begin
        void'(dq.pop_front());
        if (dq.size() > 0) tx_data = dq[0];
        else tx_valid = 1'b0;
      end
    end
    @(negedge usb_clk);
    chk4({tag, "_idle"}, {txoe, tx_busy, txp, txm}, idle_exp(low_speed));
  endtask

  initial begin
    txreset = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; generate_eop = 1'b0; low_speed = 1'b0;
    #1;
    chk4("rst_fs", {txoe, tx_busy, txp, txm}, 4'b0010);
    chki("rst_ready", int'(tx_ready), 0);
    low_speed = 1'b1;
    #1;
    chk4("rst_ls", {txoe, tx_busy, txp, txm}, 4'b0001);
    low_speed = 1'b0;
    repeat (2) @(posedge usb_clk);
    @(negedge usb_clk);
    txreset = 1'b0;
    repeat (2) @(posedge usb_clk);

    // FS single byte 0xA5
    dq = '{8'hA5};
    start_pkt();
    run("a5", "KJKJKJKKKJJKJJKK00J", 4, 1'b0, 0);
    chki("a5_nrdy", nrdy, 1);
    chki("a5_rdy_cyc", rdy1, 32);

    // FS 0xFF with a stuff bit
    dq = '{8'hFF};
    start_pkt();
    run("ff", "KJKJKJKKKKKKKJJJJ00J", 4, 1'b0, 0);
    chki("ff_nrdy", nrdy, 1);
    chki("ff_rdy_cyc", rdy1, 32);

    // LS 0x00; low_speed flips mid-packet and must be ignored
    low_speed = 1'b1;
    repeat (2) @(posedge usb_clk);
    #1;
    chk4("ls_idle", {txoe, tx_busy, txp, txm}, 4'b0001);
    dq = '{8'h00};
    start_pkt();
    low_speed = 1'b0;
    run("ls00", "KJKJKJKKJKJKJKJK00J", 32, 1'b1, 0);
    chki("ls00_nrdy", nrdy, 1);
    chki("ls00_rdy_cyc", rdy1, 256);

    // LS keep-alive EOP
    low_speed = 1'b1;
    repeat (2) @(posedge usb_clk);
    @(negedge usb_clk);
    generate_eop = 1'b1;
    @(posedge usb_clk);
    #1;
    generate_eop = 1'b0;
    run("keep", "00J", 32, 1'b1, 0);
    chki("keep_nrdy", nrdy, 0);

    // FS two-byte packet
    low_speed = 1'b0;
    repeat (2) @(posedge usb_clk);
    dq = '{8'h3C, 8'hC3};
    start_pkt();
    run("two", "KJKJKJKKJKKKKKJKKKJKJKKK00J", 4, 1'b0, 0);
    chki("two_nrdy", nrdy, 2);
    chki("two_rdy1", rdy1, 32);
    chki("two_rdy2", rdy2, 64);

    // Reset during bit 3 of the second byte
    dq = '{8'h3C, 8'hC3};
    start_pkt();
    run("abort", "KJKJKJKKJKKKKKJKKKJKJKKK00J", 4, 1'b0, 78);
    txreset = 1'b1;
    #1;
    chk4("abort_rst", {txoe, tx_busy, txp, txm}, 4'b0010);
    chki("abort_ready", int'(tx_ready), 0);
    tx_valid = 1'b0;
    repeat (2) @(posedge usb_clk);
    @(negedge usb_clk);
    txreset = 1'b0;
    @(posedge usb_clk);
    dq = '{8'hA5};
    start_pkt();
    run("after", "KJKJKJKKKJJKJJKK00J", 4, 1'b0, 0);
    chki("after_nrdy", nrdy, 1);
    chki("after_rdy_cyc", rdy1, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/softusb_tx.md
Name: softusb_tx

Overview:
- USB 1.1 low/full-speed transmitter for the softusb core; the transmit-side counterpart of the NRZI receiver/DPLL.
- Takes bytes from the protocol engine over a valid/ready handshake. Prepends SYNC, bit-stuffs, NRZI-encodes and appends EOP.
- Drives the transceiver's txp/txm/txoe pins.
- Also generates standalone EOPs for low-speed keep-alive.

Parameters:
- none (timing fixed: usb_clk = 48 MHz; FS bit = 4 cycles, LS bit = 32 cycles)

Ports:
- usb_clk  in  1  48 MHz clock
- txreset  in  1  reset, asynchronous, active-high
- tx_data  in  8  byte to send, LSB first
- tx_valid  in  1  byte available / packet continues
- tx_ready  out  1  one-cycle pulse: tx_data consumed this cycle
- generate_eop  in  1  one-cycle request for a bare EOP (keep-alive); honoured only in IDLE
- tx_busy  out  1  high from start until the EOP J bit ends
- low_speed  in  1  1 = LS timing and polarity; latched at packet/EOP start
- txp  out  1  D+ drive
- txm  out  1  D- drive
- txoe  out  1  output enable

Behaviour:
- Reset values (async): txoe=0, tx_ready=0, tx_busy=0, txp/txm=J of current low_speed (FS: 1/0, LS: 0/1), state IDLE, divider 0.
- Polarity: J = (txp=~ls_l, txm=ls_l); K = inverse; SE0 = 0/0. ls_l is the latched low_speed.
- Bit timing:
  - Bit counter restarts at start.
  - bit_ce every 4 cycles (FS) or every 32 cycles (LS).
  - Each line symbol is held exactly one bit period.
- FSM states: IDLE, SYNC, DATA, EOP1 (SE0), EOP2 (SE0), EOPJ.
- IDLE -> SYNC: on tx_valid=1.
  - Latch ls_l; tx_busy=1.
  - Next cycle: txoe=1 and first SYNC symbol (K) on the line.
  - tx_valid has priority over generate_eop.
- IDLE -> EOP1: on generate_eop=1 with tx_valid=0. tx_busy=1 and txoe=1 next cycle.
- SYNC: shifts 0x80 LSB first (KJKJKJKK). After the last bit, ones counter = 1.
- Byte boundary (end of 8th bit of SYNC or DATA, after any due stuff bit):
  - If tx_valid=1: load tx_data, pulse tx_ready the same cycle, go to DATA.
  - Else go to EOP1.
  - tx_valid is sampled only at boundaries; changes mid-byte are ignored.
- NRZI encoding: a 0 toggles the line; a 1 holds it.
- Bit stuffing:
  - Ones counter increments on each 1 and clears on each 0.
  - At count 6, insert one extra 0 (toggle) before the next data bit, then clear the counter.
  - The counter spans byte boundaries.
  - A stuff bit due after the final bit is sent before EOP.
- EOP1/EOP2: SE0 for one bit each. EOPJ: J for one bit.
- After EOPJ: txoe=0, tx_busy=0, back to IDLE. Line holds J.
- Back-to-back packets: a new tx_valid is accepted no earlier than the cycle after tx_busy falls.
- Mid-packet reset: all outputs go to reset values immediately; no EOP is emitted.
- low_speed changes while tx_busy=1 are ignored until IDLE.

Decomposition:
- Shared package softusb_pkg:
  - SYNC_BYTE=8'h80
  - FS_BIT_CYCLES=4, LS_BIT_CYCLES=32
  - STUFF_LIMIT=6
  - tx state encoding
- One sub-module, softusb_tx_nrzi: holds the ones counter and current line level. Inputs: bit_ce, bit value, se0/j force. Outputs: stuff_req and txp/txm.

Test Plan:
- FS, single byte 0xA5 then tx_valid=0.
  - Line per 4-cycle bit: K J K J K J K K | K J J K J J K K | SE0 SE0 J.
  - 19 bit times (76 cycles) with txoe=1.
  - One tx_ready pulse, at cycle 32 after start.
- FS, 0xFF with tx_valid dropped after tx_ready.
  - After SYNC: K K K K K, stuff J, J J J, SE0 SE0 J.
  - 20 bit times.
- LS, byte 0x00.
  - Every symbol lasts 32 cycles.
  - Polarity inverted (idle txp=0/txm=1).
  - Data toggles each bit: J K J K J K J K, then SE0 SE0 J.
- Keep-alive: LS idle, generate_eop pulse.
  - txoe=1 for 96 cycles: SE0 (64 cycles) then J (32 cycles).
  - tx_ready stays 0; tx_busy falls at the end.
- Reset mid-packet: assert txreset during DATA bit 3 of the second byte.
  - Same cycle: txoe=0, tx_busy=0, J levels.
  - After release, a new packet starts cleanly with SYNC.
- Two-byte packet 0x3C, 0xC3, tx_valid held.
  - tx_ready pulses exactly twice, 32 cycles apart.
  - No gap symbols between bytes; EOP follows immediately.
